uart_decoder: RTL and testbench
===============================

UART_DECODER -- requirements
Module: uart_decoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 i_rx_stb  input  1  one-cycle pulse: i_rx_data holds a received UART byte.
REQ-005 i_rx_data  input  8  received ASCII byte; sampled only when i_rx_stb=1.
REQ-006 i_busy  input  1  downstream bus busy; a word is not issued while it is 1.
REQ-007 o_stb  output  1  one-cycle pulse: o_word is valid.
REQ-008 o_word  output  34  [33:32] command code, [31:0] hex payload.
REQ-009 o_err  output  1  one-cycle pulse: frame discarded (bad character or overrun).
REQ-010 o_pend  output  1  high while a completed word waits for i_busy to drop.

Function
REQ-011 The states SHALL be IDLE, COLLECT and PEND.
REQ-012 In IDLE, a byte 'W' (0x57), 'A' (0x41) or 'R' (0x52) SHALL load code 2'b00, 2'b01 or 2'b10 respectively, clear the payload and digit count, and enter COLLECT.
REQ-013 In IDLE, CR (0x0D), LF (0x0A) and space (0x20) SHALL be ignored silently; any other byte SHALL pulse o_err and remain in IDLE.
REQ-014 In COLLECT, '0'-'9', 'a'-'f' and 'A'-'F' SHALL shift in: payload <= {payload[27:0], nibble}.
REQ-015 With more than 8 digits, the payload SHALL keep only the last 8 digits: older nibbles shift out, with no error.
REQ-016 In COLLECT, CR or LF SHALL complete the frame; zero digits is legal and yields payload 0.
REQ-017 In COLLECT, any other byte SHALL discard the frame, pulse o_err and return to IDLE.
REQ-018 On completion with i_busy=0, o_stb SHALL pulse on the next cycle (1-cycle latency after the terminator's i_rx_stb), with o_word={code,payload}, and the FSM SHALL enter IDLE.
REQ-019 On completion with i_busy=1, the FSM SHALL enter PEND with o_pend=1.
REQ-020 In PEND, o_stb SHALL pulse on the first cycle in which i_busy=0, then the FSM SHALL go to IDLE.
REQ-021 A byte arriving during PEND SHALL be dropped and pulse o_err; the pending word SHALL be preserved.
REQ-022 If a PEND byte arrives in the same cycle that i_busy falls, the word SHALL still issue, and the byte SHALL be dropped with o_err.
REQ-023 o_word SHALL hold its last issued value between o_stb pulses.
REQ-024 o_stb and o_err SHALL never be high for more than one consecutive cycle per event.
REQ-025 i_rx_data SHALL be ignored whenever i_rx_stb=0.

Reset
REQ-026 When i_reset=0, the block SHALL immediately force: FSM=IDLE, o_stb=0, o_err=0, o_pend=0, o_word=0, payload=0, digit count=0.
REQ-027 Reset mid-frame or during PEND SHALL discard the frame; no o_stb SHALL follow reset release.
REQ-028 The first byte accepted after reset release SHALL be processed as in IDLE.

Verification
REQ-029 "W1234abcd\n" with i_busy=0 -> a single o_stb one cycle after LF, o_word=34'h0_1234ABCD, o_err never high.
REQ-030 "A\r" -> o_word={2'b01,32'h0}; "RFFFFFFFF5\n" -> o_word={2'b10,32'hFFFFFFF5}.
REQ-031 "Wx12\n" -> o_err pulses on 'x', no o_stb; the following "R7\n" -> o_word={2'b10,32'h7}.
REQ-032 "W5\n" with i_busy=1 for 10 cycles after LF -> o_pend=1 for those cycles; o_stb fires on the first cycle with i_busy=0, o_word={2'b00,32'h5}; a byte sent during PEND pulses o_err and leaves the word unchanged.
REQ-033 Assert i_reset=0 after "W12" -> all outputs 0 at once; after release, "\n" produces no o_stb, and "Z" pulses o_err.
REQ-034 Back-to-back frames "W1\nW2\n" with single-cycle byte spacing -> two o_stb pulses, payloads 1 then 2, no o_err.

Source files
------------

// File: rtl/uart_decoder.sv
// ASCII command decoder: assembles "<W|A|R><hex digits><CR|LF>" frames from a
// byte stream into a 34-bit {code, payload} word, holding it while the bus is busy.
`timescale 1ns/1ps

module uart_decoder (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  input  logic        i_busy,
  output logic        o_stb,
  output logic [33:0] o_word,
  output logic        o_err,
  output logic        o_pend
);

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PEND
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_code, w_code_nxt;
  logic [31:0] r_payload, w_payload_nxt;
  logic [3:0]  r_count, w_count_nxt;
  logic        r_stb, w_stb_nxt;
  logic        r_err, w_err_nxt;
  logic [33:0] r_word, w_word_nxt;

  logic        w_is_hex;
  logic [3:0]  w_nibble;
  logic        w_is_term;
  logic        w_is_blank;

  // Letters map through their low nibble: 'A'/'a' have low nibble 1, value 10.
  always_comb begin
    w_is_hex = 1'b1;
    w_nibble = 4'd0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      w_nibble = i_rx_data[3:0];
    end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                 (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
      w_nibble = i_rx_data[3:0] + 4'd9;
    end else begin
      w_is_hex = 1'b0;
    end
  end

  assign w_is_term  = (i_rx_data == CH_CR) || (i_rx_data == CH_LF);
  assign w_is_blank = w_is_term || (i_rx_data == CH_SP);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_payload_nxt = r_payload;
    w_count_nxt   = r_count;
    w_stb_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_word_nxt    = r_word;

    unique case (r_state)
      S_IDLE: begin
        if (i_rx_stb) begin
          if (i_rx_data == CH_W || i_rx_data == CH_A || i_rx_data == CH_R) begin
            w_code_nxt    = (i_rx_data == CH_W) ? 2'b00 :
                            (i_rx_data == CH_A) ? 2'b01 : 2'b10;
            w_payload_nxt = 32'd0;
            w_count_nxt   = 4'd0;
            w_state_nxt   = S_COLLECT;
          end else if (!w_is_blank) begin
            w_err_nxt = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (i_rx_stb) begin
          if (w_is_hex) begin
            // Only the newest eight digits survive; older nibbles fall off the top.
            w_payload_nxt = {r_payload[27:0], w_nibble};
            w_count_nxt   = (r_count == 4'd8) ? r_count : r_count + 4'd1;
          end else if (w_is_term) begin
            if (i_busy) begin
              w_state_nxt = S_PEND;
            end else begin
              w_stb_nxt   = 1'b1;
              w_word_nxt  = {r_code, r_payload};
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_PEND: begin
        if (i_rx_stb) begin
          w_err_nxt = 1'b1;
        end
        if (!i_busy) begin
          w_stb_nxt   = 1'b1;
          w_word_nxt  = {r_code, r_payload};
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_code    <= 2'b00;
      r_payload <= 32'd0;
      r_count   <= 4'd0;
      r_stb     <= 1'b0;
      r_err     <= 1'b0;
      r_word    <= 34'd0;
    end else begin
      r_code    <= w_code_nxt;
      r_payload <= w_payload_nxt;
      r_count   <= w_count_nxt;
      r_stb     <= w_stb_nxt;
      r_err     <= w_err_nxt;
      r_word    <= w_word_nxt;
    end
  end

  assign o_stb  = r_stb;
  assign o_err  = r_err;
  assign o_word = r_word;
  assign o_pend = (r_state == S_PEND);

endmodule

// File: tb/tb_uart_decoder.sv
// Directed bench for uart_decoder: expected words are queued as frames are sent
// and popped by a monitor whenever o_stb fires.
`timescale 1ns/1ps

module tb_uart_decoder;

  logic        i_clk;
  logic        i_reset;
  logic        i_rx_stb;
  logic [7:0]  i_rx_data;
  logic        i_busy;
  logic        o_stb;
  logic [33:0] o_word;
  logic        o_err;
  logic        o_pend;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] SP = 8'h20;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_seen = 0;
  int err_seen = 0;
  int s0, e0;
  logic prev_stb = 1'b0;
  logic prev_err = 1'b0;
  logic [33:0] sb[$];

  uart_decoder dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rx_stb  (i_rx_stb),
    .i_rx_data (i_rx_data),
    .i_busy    (i_busy),
    .o_stb     (o_stb),
    .o_word    (o_word),
    .o_err     (o_err),
    .o_pend    (o_pend)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Callers sit 1ns after a rising edge; each byte occupies exactly one cycle.
  task automatic send_byte(input logic [7:0] b);
    i_rx_stb  = 1'b1;
    i_rx_data = b;
    @(posedge i_clk); #1;
    i_rx_stb  = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (i != s.len() - 1) idle(gap);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge i_clk) begin
    if (i_reset) begin
      if (o_stb) begin
        stb_seen++;
        check("stb_single", {63'd0, prev_stb}, 64'd0);
        check("stb_expected", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) check("sb_word", {30'd0, o_word}, {30'd0, sb.pop_front()});
      end
      if (o_err) begin
        err_seen++;
        check("err_single", {63'd0, prev_err}, 64'd0);
      end
    end
    prev_stb = o_stb;
    prev_err = o_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0; i_rx_stb = 1'b0; i_rx_data = 8'h00; i_busy = 1'b0;
    #12;
    check("rst_stb",  {63'd0, o_stb},  64'd0);
    check("rst_err",  {63'd0, o_err},  64'd0);
    check("rst_pend", {63'd0, o_pend}, 64'd0);
    check("rst_word", {30'd0, o_word}, 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    idle(1);

    // Basic write frame with lowercase hex
    s0 = stb_seen; e0 = err_seen;
    sb.push_back({2'b00, 32'h1234ABCD});
    send_str("W1234abcd", 1);
    send_byte(LF);
    check("lat_w", {63'd0, o_stb}, 64'd1);
    check("word_w", {30'd0, o_word}, {30'd0, 2'b00, 32'h1234ABCD});
    idle(1);
    check("stb_drop_w", {63'd0, o_stb}, 64'd0);
    idle(1);
    check("nstb_w", stb_seen - s0, 1);
    check("nerr_w", err_seen - e0, 0);

    // Zero digits, then more than eight digits with uppercase hex
    sb.push_back({2'b01, 32'h0});
    send_str("A", 1);
    send_byte(CR);
    check("lat_a", {63'd0, o_stb}, 64'd1);
    check("word_a", {30'd0, o_word}, {30'd0, 2'b01, 32'h0});
    idle(1);
    sb.push_back({2'b10, 32'hFFFFFFF5});
    send_str("RFFFFFFFF5", 1);
    send_byte(LF);
    check("lat_r9", {63'd0, o_stb}, 64'd1);
    check("word_r9", {30'd0, o_word}, {30'd0, 2'b10, 32'hFFFFFFF5});
    idle(2);

    // Bad character discards the frame; trailing digits are errors in IDLE
    s0 = stb_seen; e0 = err_seen;
    send_str("Wx", 1);
    check("err_x", {63'd0, o_err}, 64'd1);
    check("stb_x", {63'd0, o_stb}, 64'd0);
    idle(1);
    check("err_x_drop", {63'd0, o_err}, 64'd0);
    send_str("12", 1);
    send_byte(LF);
    idle(2);
    check("nerr_bad", err_seen - e0, 3);
    check("nstb_bad", stb_seen - s0, 0);
    sb.push_back({2'b10, 32'h7});
    send_str("R7", 1);
    send_byte(LF);
    check("lat_r7", {63'd0, o_stb}, 64'd1);
    check("word_r7", {30'd0, o_word}, {30'd0, 2'b10, 32'h7});
    idle(2);

    // Busy downstream: word waits in PEND, a stray byte is dropped
    i_busy = 1'b1;
    send_str("W5", 1);
    send_byte(LF);
    check("pend_enter", {63'd0, o_pend}, 64'd1);
    check("pend_nostb", {63'd0, o_stb}, 64'd0);
    s0 = stb_seen;
    for (int k = 0; k < 10; k++) begin
      check("pend_hold", {63'd0, o_pend}, 64'd1);
      check("word_hold", {30'd0, o_word}, {30'd0, 2'b10, 32'h7});
      if (k == 4) begin
        send_byte(8'h57);
        check("err_in_pend", {63'd0, o_err}, 64'd1);
      end else begin
        idle(1);
      end
    end
    check("nstb_pend", stb_seen - s0, 0);
    sb.push_back({2'b00, 32'h5});
    i_busy = 1'b0;
    idle(1);
    check("stb_release", {63'd0, o_stb}, 64'd1);
    check("word_release", {30'd0, o_word}, {30'd0, 2'b00, 32'h5});
    check("pend_exit", {63'd0, o_pend}, 64'd0);
    idle(1);
    check("stb_release_drop", {63'd0, o_stb}, 64'd0);

    // Byte arriving in the same cycle busy falls
    i_busy = 1'b1;
    send_str("A9", 1);
    send_byte(LF);
    idle(2);
    check("pend_a9", {63'd0, o_pend}, 64'd1);
    sb.push_back({2'b01, 32'h9});
    i_busy = 1'b0;
    send_byte(8'h51);
    check("same_cyc_stb", {63'd0, o_stb}, 64'd1);
    check("same_cyc_err", {63'd0, o_err}, 64'd1);
    check("same_cyc_word", {30'd0, o_word}, {30'd0, 2'b01, 32'h9});
    idle(1);
    check("same_cyc_idle", {63'd0, o_pend}, 64'd0);

    // Asynchronous reset mid-frame and during PEND
    send_str("W12", 1);
    #3 i_reset = 1'b0;
    #1;
    check("arst_word", {30'd0, o_word}, 64'd0);
    check("arst_stb",  {63'd0, o_stb},  64'd0);
    check("arst_err",  {63'd0, o_err},  64'd0);
    check("arst_pend", {63'd0, o_pend}, 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    s0 = stb_seen; e0 = err_seen;
    send_byte(LF);
    idle(2);
    check("post_rst_nstb", stb_seen - s0, 0);
    check("post_rst_nerr", err_seen - e0, 0);
    send_byte(8'h5A);
    check("post_rst_err_z", {63'd0, o_err}, 64'd1);
    idle(1);
    i_busy = 1'b1;
    send_str("R3", 1);
    send_byte(LF);
    check("pend_r3", {63'd0, o_pend}, 64'd1);
    #3 i_reset = 1'b0;
    #1;
    check("arst_pend_clr", {63'd0, o_pend}, 64'd0);
    @(posedge i_clk); #1;
    i_busy  = 1'b0;
    i_reset = 1'b1;
    idle(3);
    check("pend_rst_nstb", stb_seen - s0, 0);

    // Back-to-back frames, preceded by ignored whitespace
    s0 = stb_seen; e0 = err_seen;
    sb.push_back({2'b00, 32'h1});
    sb.push_back({2'b00, 32'h2});
    send_byte(SP);
    send_byte(CR);
    send_str("W1", 0);
    send_byte(LF);
    send_str("W2", 0);
    send_byte(LF);
    check("b2b_word2", {30'd0, o_word}, {30'd0, 2'b00, 32'h2});
    idle(2);
    check("b2b_nstb", stb_seen - s0, 2);
    check("b2b_nerr", err_seen - e0, 0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    check("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
